// File: rtl/alu_exec_step_3.sv
// Execute-stage ALU for the multicycle CPU: single-cycle ops plus iterative variable shifts.
// Optional overflow flag enabled by defining ALU_EXEC_OVERFLOW_EN.
module alu_exec_step_3 #(
    parameter int WIDTH     = 32,
    parameter int IMM_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 control_mux_for_alu,
    input  logic [5:0]           alu_op,
    input  logic [WIDTH-1:0]     reg_a,
    input  logic [WIDTH-1:0]     reg_b,
    input  logic [IMM_WIDTH-1:0] imm,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
`ifdef ALU_EXEC_OVERFLOW_EN
    output logic                 overflow,
`endif
    output logic                 zero
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    localparam logic [5:0] OP_ADD  = 6'b100000;
    localparam logic [5:0] OP_SUB  = 6'b100010;
    localparam logic [5:0] OP_AND  = 6'b100100;
    localparam logic [5:0] OP_OR   = 6'b100101;
    localparam logic [5:0] OP_NOR  = 6'b100111;
    localparam logic [5:0] OP_SLT  = 6'b101010;
    localparam logic [5:0] OP_SLLV = 6'b000100;
    localparam logic [5:0] OP_SRLV = 6'b000110;

    logic [1:0]       state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [5:0]       op_r;
    logic [WIDTH-1:0] shreg_r;
    logic [4:0]       cnt_r;

    logic [WIDTH-1:0] exec_res_s;
    logic             exec_ovf_s;
    logic             is_shift_s;
    logic [4:0]       amt_s;
    logic [WIDTH-1:0] shift_next_s;
    logic [WIDTH-1:0] b_sel_s;

    assign b_sel_s = control_mux_for_alu
                   ? {{(WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm}
                   : reg_b;
    assign amt_s      = b_r[4:0];
    assign is_shift_s = (op_r == OP_SLLV) || (op_r == OP_SRLV);

    // One-step shift in the direction selected by the latched opcode.
    always_comb begin
        shift_next_s = shreg_r;
        if (op_r == OP_SRLV) begin
            shift_next_s = {1'b0, shreg_r[WIDTH-1:1]};
        end else begin
            shift_next_s = {shreg_r[WIDTH-2:0], 1'b0};
        end
    end

    // Single-cycle result and signed-overflow detection for the latched operation.
    always_comb begin
        exec_res_s = {WIDTH{1'b0}};
        exec_ovf_s = 1'b0;
        case (op_r)
            OP_ADD: begin
                exec_res_s = a_r + b_r;
                exec_ovf_s = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (exec_res_s[WIDTH-1] != a_r[WIDTH-1]);
            end
            OP_SUB: begin
                exec_res_s = a_r - b_r;
                exec_ovf_s = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (exec_res_s[WIDTH-1] != a_r[WIDTH-1]);
            end
            OP_AND:  exec_res_s = a_r & b_r;
            OP_OR:   exec_res_s = a_r | b_r;
            OP_NOR:  exec_res_s = ~(a_r | b_r);
            OP_SLT:  exec_res_s = ($signed(a_r) < $signed(b_r)) ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b0}};
            // Zero-amount shifts complete here with the operand unchanged.
            OP_SLLV: exec_res_s = a_r;
            OP_SRLV: exec_res_s = a_r;
            default: exec_res_s = {WIDTH{1'b0}};
        endcase
    end

    // Control FSM, operand latches and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            op_r    <= 6'd0;
            shreg_r <= {WIDTH{1'b0}};
            cnt_r   <= 5'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= {WIDTH{1'b0}};
            zero    <= 1'b0;
`ifdef ALU_EXEC_OVERFLOW_EN
            overflow <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r     <= reg_a;
                        b_r     <= b_sel_s;
                        op_r    <= alu_op;
                        busy    <= 1'b1;
                        state_r <= ST_EXEC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (is_shift_s && (amt_s != 5'd0)) begin
                        shreg_r <= a_r;
                        cnt_r   <= amt_s;
                        state_r <= ST_SHIFT;
                    end else begin
                        result  <= exec_res_s;
                        zero    <= (exec_res_s == {WIDTH{1'b0}});
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
`ifdef ALU_EXEC_OVERFLOW_EN
                        overflow <= exec_ovf_s;
`endif
                    end
                end
                ST_SHIFT: begin
                    shreg_r <= shift_next_s;
                    cnt_r   <= cnt_r - 5'd1;
                    if (cnt_r == 5'd1) begin
                        result  <= shift_next_s;
                        zero    <= (shift_next_s == {WIDTH{1'b0}});
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
`ifdef ALU_EXEC_OVERFLOW_EN
                        overflow <= 1'b0;
`endif
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_exec_step_3.md
Name: alu_exec_step_3

Overview:
- Execute-stage ALU datapath for the multicycle CPU.
- Consumes control_mux_for_alu and alu_op from the step-3 controller, plus register/immediate operands from decode.
- Produces a registered result and zero flag for the memory/writeback steps and beq resolution.
- Single-cycle ops finish in one EXEC cycle; variable shifts run iteratively, one bit per cycle, behind a start/done handshake.

Parameters:
- WIDTH, 32, datapath width of operands and result.
- IMM_WIDTH, 16, immediate width; sign-extended to WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- control_mux_for_alu  input  1  operand-B select: 0 = reg_b, 1 = sign-extended imm.
- alu_op  input  6  operation code (MIPS funct encoding).
- reg_a  input  WIDTH  operand A.
- reg_b  input  WIDTH  register operand B.
- imm  input  IMM_WIDTH  immediate operand.
- busy  output  1  high from the edge after start is accepted until the done edge.
- done  output  1  one-cycle pulse; result and zero are valid from this cycle on.
- result  output  WIDTH  registered result; holds until the next completion.
- zero  output  1  (result == 0), registered with result.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - busy, done, result, zero = 0; shift counter = 0.
  - An in-flight operation is discarded.
- FSM states: IDLE, EXEC, SHIFT.
- IDLE:
  - If start = 1 at edge k: latch A = reg_a, B = control_mux_for_alu ? sign_ext(imm) : reg_b, and alu_op. Go to EXEC; busy = 1.
  - If start = 0: stay in IDLE.
  - done is forced to 0 in every cycle except the completion cycle.
- EXEC (edge k+1):
  - 100000 add: A + B, wrap modulo 2^WIDTH.
  - 100010 sub: A - B, wrap modulo 2^WIDTH.
  - 100100 and; 100101 or; 100111 nor.
  - 101010 slt: signed compare, result 1 or 0.
  - 000100 sllv / 000110 srlv (logical):
    - Shift A by B[4:0].
    - If amount = 0: result = A, complete at this edge.
    - Otherwise load the shift register with A and the counter with the amount; go to SHIFT. No completion at this edge.
  - 000000 (nop/jump) or any unlisted code: result = 0, zero = 1.
  - Completion: write result/zero, done = 1, busy = 0, go to IDLE.
- SHIFT:
  - Each edge: shift by 1 in the selected direction and decrement the counter.
  - On the edge where the counter goes 1 -> 0: write result/zero, done = 1, busy = 0, go to IDLE.
  - A shift by n completes at edge k+1+n; maximum latency is 32 cycles after acceptance.
- Handshake:
  - start while busy is ignored, with no queuing.
  - start in the same cycle done is high (state is IDLE) is accepted normally, giving back-to-back operations.
  - Operand and alu_op changes after acceptance have no effect.
- Widths:
  - Shift amount is always B[4:0]; upper bits of B are ignored.
  - Immediate is sign-extended, so imm 16'hFFFF gives B = 32'hFFFFFFFF.

Optional Feature:
- Macro ALU_EXEC_OVERFLOW_EN.
- Defined:
  - Adds output overflow (1 bit), reset 0, registered with result.
  - Set on add when operand signs match and the result sign differs; set on sub when operand signs differ and the result sign differs from A.
  - Cleared on every other completion.
  - result is still written (wrapped value).
- Undefined: the port and its logic are absent; add/sub behaviour is unchanged.

Test Plan:
- Reset then idle -> busy = 0, done = 0, result = 0, zero = 0. Assert rst mid-SHIFT -> all outputs 0 immediately, state IDLE, and no done pulse follows.
- add, reg_a = 5, reg_b = 7, mux = 0, start at edge k -> done at edge k+1, result = 12, zero = 0. Then addi with mux = 1, imm = 16'hFFFF, reg_a = 1 -> result = 0, zero = 1.
- sub/beq, reg_a = reg_b = 32'h1234 -> result = 0, zero = 1. slt with reg_a = 32'hFFFFFFFF, reg_b = 1 -> result = 1.
- sllv, reg_a = 1, reg_b = 31 -> busy for 32 cycles, done at edge k+32, result = 32'h80000000. sllv with amount 0 -> done at edge k+1, result = A.
- start held high throughout a shift -> extra requests ignored. start in the done cycle -> next op accepted; done pulses exactly once per op.
- With ALU_EXEC_OVERFLOW_EN: add 32'h7FFFFFFF + 1 -> result = 32'h80000000, overflow = 1. Next add 1 + 1 -> overflow = 0.
